// File: rtl/phase_scheduler.sv
// Four-approach signal phase scheduler with a pedestrian walk phase.
// Round-robin arbitration among vehicle requests, minimum/maximum green
// timing, fixed yellow, all-red clearance and walk durations.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_ALL_RED | clearance; arbitrates once ALL_RED_T cycles have elapsed
// S_GREEN   | approach cur has green; held MIN_GREEN, forced off at MAX_GREEN
// S_YELLOW  | approach cur has yellow for exactly YELLOW_T cycles
// S_WALK    | pedestrian walk for exactly WALK_T cycles; cur is untouched
module phase_scheduler #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       ped_req,
    output logic [3:0] grant,
    output logic [3:0] yellow,
    output logic       walk,
    output logic       all_red,
    output logic       phase_done
);

    // Reject parameter sets the 8-bit dwell counter or the timing rules cannot honour.
    if (MIN_GREEN < 1 || MIN_GREEN > 255) begin : g_bad_min_green
        $error("phase_scheduler: MIN_GREEN must be in 1..255");
    end
    if (MAX_GREEN < MIN_GREEN || MAX_GREEN > 255) begin : g_bad_max_green
        $error("phase_scheduler: MAX_GREEN must be in MIN_GREEN..255");
    end
    if (YELLOW_T < 1 || YELLOW_T > 255) begin : g_bad_yellow
        $error("phase_scheduler: YELLOW_T must be in 1..255");
    end
    if (ALL_RED_T < 1 || ALL_RED_T > 255) begin : g_bad_all_red
        $error("phase_scheduler: ALL_RED_T must be in 1..255");
    end
    if (WALK_T < 1 || WALK_T > 255) begin : g_bad_walk
        $error("phase_scheduler: WALK_T must be in 1..255");
    end

    // dwell counts completed cycles in the current state, so the Nth cycle of
    // a state sees dwell == N-1; every limit below is therefore "count - 1".
    localparam logic [7:0] MIN_LAST     = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_LAST     = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST  = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALL_RED_LAST = 8'(ALL_RED_T - 1);
    localparam logic [7:0] WALK_LAST    = 8'(WALK_T - 1);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_WALK    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dwell;
    logic [1:0] cur;
    logic [1:0] cur_nxt;
    logic       ped_pending;
    logic [3:0] cur_oh;
    logic       other_req;
    logic [1:0] rr_pick;
    logic       rr_found;
    logic       enter_walk;

    assign cur_oh     = 4'b0001 << cur;
    assign other_req  = |(req & ~cur_oh);
    assign enter_walk = (state_nxt == S_WALK) && (state != S_WALK);

    // Round-robin search for the first requesting approach after cur.
    always_comb begin : p_rr_search
        logic [1:0] idx;
        rr_found = 1'b0;
        rr_pick  = cur;
        idx      = cur;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!rr_found && req[idx]) begin
                rr_pick  = idx;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state and next-pointer decision.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        unique case (state)
            S_ALL_RED: begin
                if (dwell >= ALL_RED_LAST) begin
                    if (ped_pending) begin
                        state_nxt = S_WALK;
                    end else if (rr_found) begin
                        state_nxt = S_GREEN;
                        cur_nxt   = rr_pick;
                    end
                end
            end
            S_GREEN: begin
                if (dwell >= MIN_LAST) begin
                    if (!req[cur]) begin
                        state_nxt = S_YELLOW;
                    end else if ((dwell >= MAX_LAST) && (other_req || ped_pending)) begin
                        state_nxt = S_YELLOW;
                    end
                end
            end
            S_YELLOW: begin
                if (dwell == YELLOW_LAST) begin
                    state_nxt = S_ALL_RED;
                end
            end
            S_WALK: begin
                if (dwell == WALK_LAST) begin
                    state_nxt = S_ALL_RED;
                end
            end
            default: state_nxt = S_ALL_RED;
        endcase
    end

    // State and grant pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_ALL_RED;
            cur   <= 2'd3;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // Dwell counter: cleared on state entry, saturates so a long idle or green never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell <= 8'd0;
        end else if (state_nxt != state) begin
            dwell <= 8'd0;
        end else if (dwell != 8'hFF) begin
            dwell <= dwell + 8'd1;
        end
    end

    // Pedestrian latch; a press on the walk-entry cycle is kept for the next walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end else if (enter_walk) begin
            ped_pending <= 1'b0;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        grant      = 4'b0000;
        yellow     = 4'b0000;
        walk       = 1'b0;
        all_red    = 1'b0;
        phase_done = 1'b0;
        unique case (state)
            S_ALL_RED: all_red = 1'b1;
            S_GREEN:   grant   = cur_oh;
            S_YELLOW: begin
                yellow     = cur_oh;
                phase_done = (dwell == YELLOW_LAST);
            end
            S_WALK: begin
                walk       = 1'b1;
                phase_done = (dwell == WALK_LAST);
            end
            default: all_red = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler (default parameters).
// Expected per-cycle output patterns are queued as each scenario's stimulus
// is planned, then popped and compared against the DUT one cycle at a time.
module tb_phase_scheduler;

    localparam int YELLOW_T = 3;
    localparam int WALK_T   = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       ped_req;
    logic [3:0] grant;
    logic [3:0] yellow;
    logic       walk;
    logic       all_red;
    logic       phase_done;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    string       scen   = "init";
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    phase_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .ped_req    (ped_req),
        .grant      (grant),
        .yellow     (yellow),
        .walk       (walk),
        .all_red    (all_red),
        .phase_done (phase_done)
    );

    // pattern = {grant, yellow, walk, all_red, phase_done}
    function automatic logic [10:0] pat_green(input int a);
        logic [3:0] oh;
        oh = 4'(1 << a);
        return {oh, 4'b0000, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic logic [10:0] pat_yellow(input int a, input logic done);
        logic [3:0] oh;
        oh = 4'(1 << a);
        return {4'b0000, oh, 1'b0, 1'b0, done};
    endfunction

    function automatic logic [10:0] pat_walk(input logic done);
        return {8'b0, 1'b1, 1'b0, done};
    endfunction

    function automatic logic [10:0] pat_red();
        return {8'b0, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_green(input int a, input int n);
        for (int i = 0; i < n; i++) sb.push_back(pat_green(a));
    endtask

    task automatic push_yellow(input int a);
        for (int i = 0; i < YELLOW_T - 1; i++) sb.push_back(pat_yellow(a, 1'b0));
        sb.push_back(pat_yellow(a, 1'b1));
    endtask

    task automatic push_walk();
        for (int i = 0; i < WALK_T - 1; i++) sb.push_back(pat_walk(1'b0));
        sb.push_back(pat_walk(1'b1));
    endtask

    task automatic push_red(input int n);
        for (int i = 0; i < n; i++) sb.push_back(pat_red());
    endtask

    // One clock: sample on the falling edge and compare with the queue head.
    task automatic step();
        logic [10:0] obs;
        logic [10:0] exp;
        int          active;
        @(negedge clk);
        cyc++;
        obs    = {grant, yellow, walk, all_red, phase_done};
        exp    = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
        active = int'(|grant) + int'(|yellow) + int'(walk) + int'(all_red);
        check_val($sformatf("%s_c%0d", scen, cyc), 32'(obs), 32'(exp));
        check_val($sformatf("%s_excl_c%0d", scen, cyc), 32'(active), 32'd1);
    endtask

    task automatic drain();
        while (sb.size() > 0) step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic async_reset_check(input string tag);
        #2 reset_n = 1'b0;
        #1 check_val(tag, 32'({grant, yellow, walk, all_red, phase_done}), 32'(pat_red()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        ped_req = 1'b0;

        scen = "reset";
        push_red(2);
        drain();

        // First grant after a full clearance, then release by dropping req.
        scen = "first_grant";
        req  = 4'b0100;
        release_reset();
        push_red(2);
        push_green(2, 6);
        drain();
        req = 4'b0000;
        push_yellow(2);
        push_red(3);
        drain();

        // Single-cycle request pulse gets exactly the minimum green.
        scen = "min_green";
        req  = 4'b0010;
        push_green(1, 1);
        step();
        req = 4'b0000;
        push_green(1, 4);
        push_yellow(1);
        push_red(3);
        drain();

        // All approaches requesting: forced rotation at maximum green.
        scen = "rotate";
        reset_n = 1'b0;
        req     = 4'b1111;
        push_red(1);
        drain();
        release_reset();
        push_red(2);
        for (int k = 0; k < 5; k++) begin
            push_green(k % 4, 20);
            push_yellow(k % 4);
            push_red(2);
        end
        push_green(1, 3);
        drain();
        async_reset_check("rst_mid_green");
        req = 4'b0000;
        push_red(1);
        drain();

        // Pedestrian and vehicle both pending at arbitration: walk wins.
        scen = "ped_first";
        req  = 4'b0001;
        release_reset();
        push_red(2);
        push_walk();
        push_red(2);
        push_green(0, 6);
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        drain();
        req = 4'b0000;
        push_yellow(0);
        push_red(2);
        drain();

        // Pedestrian press during an extended green forces it off at maximum.
        scen = "ped_max";
        req  = 4'b0100;
        push_green(2, 20);
        push_yellow(2);
        push_red(2);
        push_walk();
        push_red(2);
        push_green(2, 6);
        for (int k = 0; k < 3; k++) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        drain();
        req = 4'b0000;
        push_yellow(2);
        push_red(3);
        drain();

        // Reset during walk with a second press latched: no walk afterwards.
        scen    = "rst_walk";
        ped_req = 1'b1;
        push_red(1);
        step();
        ped_req = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back(pat_walk(1'b0));
        step();
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        drain();
        async_reset_check("rst_mid_walk");
        push_red(1);
        drain();
        release_reset();
        push_red(6);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
